axi_rd_arbiter: RTL and testbench

- Shares the single AXI read master port (AR/R channels) between the instruction cache refill engine and the data cache refill engine.
- Sequences exactly one outstanding read burst at a time: arbitrate, issue AR, stream R beats back to the granted requester until rlast.
- Sits between the icache/dcache AXI-side read ports and the CPU-top AXI interconnect. Write channels are not handled here.

---
 rtl/axi_rd_arbiter_pkg.sv | 22 ++
 rtl/axi_rd_arb_pick.sv | 44 ++++
 rtl/axi_rd_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi_rd_arbiter_pkg
//  Purpose  : Shared types and constants for the AXI read-port arbiter:
//             FSM state encoding, AXI burst type and default cache ids.
//  Revision : 1.0  initial release
// ============================================================================
package axi_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [3:0] ICACHE_ID  = 4'd3;
    localparam logic [3:0] DCACHE_ID  = 4'd1;
    localparam int unsigned STARVE_W  = 3;

endpackage : axi_rd_arbiter_pkg
`default_nettype wire

// File: rtl/axi_rd_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module   : axi_rd_arb_pick
//  Purpose  : Combinational arbitration choice between icache and dcache.
//             dcache has priority unless icache has lost STARVE_MAX contested
//             rounds in a row; also computes the next saturating starve count.
//  Ports    : i_ic_req / i_dc_req  - request lines from each cache
//             i_starve_cnt         - current starve count
//             o_any                - at least one request present
//             o_pick_d             - 1 = dcache wins, 0 = icache wins
//             o_starve_nxt         - starve count to store if this pick is taken
//  Revision : 1.0  initial release
// ============================================================================
module axi_rd_arb_pick
    import axi_rd_arbiter_pkg::*;
#(
    parameter logic [STARVE_W-1:0] STARVE_MAX = 3'd4
) (
    input  logic                i_ic_req,
    input  logic                i_dc_req,
    input  logic [STARVE_W-1:0] i_starve_cnt,
    output logic                o_any,
    output logic                o_pick_d,
    output logic [STARVE_W-1:0] o_starve_nxt
);

    localparam logic [STARVE_W-1:0] C_SAT = '1;

    always_comb begin
        o_any        = i_ic_req | i_dc_req;
        // icache only overrides dcache once it has been starved long enough
        o_pick_d     = i_dc_req & ~(i_ic_req & (i_starve_cnt >= STARVE_MAX));
        o_starve_nxt = i_starve_cnt;
        if (o_any) begin
            if (!o_pick_d) begin
                o_starve_nxt = '0;
            end else if (i_ic_req && (i_starve_cnt != C_SAT)) begin
                o_starve_nxt = i_starve_cnt + 1'b1;
            end
        end
    end

endmodule : axi_rd_arb_pick
`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : axi_rd_arbiter
//  Purpose  : Shares one AXI read master port (AR/R) between the icache and
//             dcache refill engines, one outstanding burst at a time.
//  Ports    : clk, resetn (async, active-low)
//             i_ar*/i_r*  - icache AR request / R response
//             d_ar*/d_r*  - dcache AR request / R response
//             m_ar*/m_r*  - shared AXI read master port
//             busy        - burst in progress (S_AR or S_R)
//             grant_d     - current/last grant, 1 = dcache
//             prot_err    - sticky R-channel protocol error
//  Revision : 1.0  initial release
// ============================================================================
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter logic [3:0]          I_ID       = ICACHE_ID,
    parameter logic [3:0]          D_ID       = DCACHE_ID,
    parameter logic [STARVE_W-1:0] STARVE_MAX = 3'd4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] i_araddr,
    input  logic [7:0]  i_arlen,
    input  logic [2:0]  i_arsize,
    input  logic        i_arvalid,
    output logic        i_arready,
    output logic [31:0] i_rdata,
    output logic [1:0]  i_rresp,
    output logic        i_rlast,
    output logic        i_rvalid,
    input  logic        i_rready,
    input  logic [31:0] d_araddr,
    input  logic [7:0]  d_arlen,
    input  logic [2:0]  d_arsize,
    input  logic        d_arvalid,
    output logic        d_arready,
    output logic [31:0] d_rdata,
    output logic [1:0]  d_rresp,
    output logic        d_rlast,
    output logic        d_rvalid,
    input  logic        d_rready,
    output logic [3:0]  m_arid,
    output logic [31:0] m_araddr,
    output logic [7:0]  m_arlen,
    output logic [2:0]  m_arsize,
    output logic [1:0]  m_arburst,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [3:0]  m_rid,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rlast,
    input  logic        m_rvalid,
    output logic        m_rready,
    output logic        busy,
    output logic        grant_d,
    output logic        prot_err
);

    state_e              state_q,    state_d;
    logic                grant_d_q,  grant_d_d;
    logic [STARVE_W-1:0] starve_q,   starve_d;
    logic [7:0]          beat_q,     beat_d;
    logic [7:0]          len_q,      len_d;
    logic                prot_err_q, prot_err_d;

    logic                w_any;
    logic                w_pick_d;
    logic [STARVE_W-1:0] w_starve_nxt;
    logic                w_ar_hs;
    logic                w_r_hs;
    logic                w_rready_g;
    logic [3:0]          w_gid;

    axi_rd_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .i_ic_req     (i_arvalid),
        .i_dc_req     (d_arvalid),
        .i_starve_cnt (starve_q),
        .o_any        (w_any),
        .o_pick_d     (w_pick_d),
        .o_starve_nxt (w_starve_nxt)
    );

    always_comb begin
        state_d    = state_q;
        grant_d_d  = grant_d_q;
        starve_d   = starve_q;
        beat_d     = beat_q;
        len_d      = len_q;
        prot_err_d = prot_err_q;

        m_arid     = '0;
        m_araddr   = '0;
        m_arlen    = '0;
        m_arsize   = '0;
        m_arburst  = BURST_INCR;
        m_arvalid  = 1'b0;
        m_rready   = 1'b0;
        i_arready  = 1'b0;
        d_arready  = 1'b0;
        i_rdata    = '0;
        i_rresp    = '0;
        i_rlast    = 1'b0;
        i_rvalid   = 1'b0;
        d_rdata    = '0;
        d_rresp    = '0;
        d_rlast    = 1'b0;
        d_rvalid   = 1'b0;

        w_gid      = grant_d_q ? D_ID : I_ID;
        w_rready_g = grant_d_q ? d_rready : i_rready;
        w_ar_hs    = 1'b0;
        w_r_hs     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_any) begin
                    grant_d_d = w_pick_d;
                    starve_d  = w_starve_nxt;
                    state_d   = S_AR;
                end
            end
            S_AR: begin
                m_arid = w_gid;
                if (grant_d_q) begin
                    m_araddr  = d_araddr;
                    m_arlen   = d_arlen;
                    m_arsize  = d_arsize;
                    m_arvalid = d_arvalid;
                    d_arready = m_arready;
                    w_ar_hs   = d_arvalid & m_arready;
                end else begin
                    m_araddr  = i_araddr;
                    m_arlen   = i_arlen;
                    m_arsize  = i_arsize;
                    m_arvalid = i_arvalid;
                    i_arready = m_arready;
                    w_ar_hs   = i_arvalid & m_arready;
                end
                if (w_ar_hs) begin
                    len_d   = m_arlen;
                    beat_d  = '0;
                    state_d = S_R;
                end
            end
            S_R: begin
                m_rready = w_rready_g;
                w_r_hs   = m_rvalid & w_rready_g;
                if (grant_d_q) begin
                    d_rdata  = m_rdata;
                    d_rresp  = m_rresp;
                    d_rlast  = m_rlast;
                    d_rvalid = m_rvalid;
                end else begin
                    i_rdata  = m_rdata;
                    i_rresp  = m_rresp;
                    i_rlast  = m_rlast;
                    i_rvalid = m_rvalid;
                end
                if (w_r_hs) begin
                    beat_d = beat_q + 8'd1;
                    // beat_q is the 0-based index of the beat now completing
                    if ((m_rid != w_gid) ||
                        ( m_rlast && (beat_q != len_q)) ||
                        (!m_rlast && (beat_q == len_q))) begin
                        prot_err_d = 1'b1;
                    end
                    // the burst ends on rlast only, even if the length disagrees
                    if (m_rlast) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            grant_d_q  <= 1'b0;
            starve_q   <= '0;
            beat_q     <= '0;
            len_q      <= '0;
            prot_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_d_q  <= grant_d_d;
            starve_q   <= starve_d;
            beat_q     <= beat_d;
            len_q      <= len_d;
            prot_err_q <= prot_err_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign grant_d  = grant_d_q;
    assign prot_err = prot_err_q;

endmodule : axi_rd_arbiter
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_rd_arbiter
//  Purpose  : Directed self-checking bench for axi_rd_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi_rd_arbiter;

    logic        clk;
    logic        resetn;
    logic [31:0] i_araddr;
    logic [7:0]  i_arlen;
    logic [2:0]  i_arsize;
    logic        i_arvalid;
    logic        i_arready;
    logic [31:0] i_rdata;
    logic [1:0]  i_rresp;
    logic        i_rlast;
    logic        i_rvalid;
    logic        i_rready;
    logic [31:0] d_araddr;
    logic [7:0]  d_arlen;
    logic [2:0]  d_arsize;
    logic        d_arvalid;
    logic        d_arready;
    logic [31:0] d_rdata;
    logic [1:0]  d_rresp;
    logic        d_rlast;
    logic        d_rvalid;
    logic        d_rready;
    logic [3:0]  m_arid;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_arvalid;
    logic        m_arready;
    logic [3:0]  m_rid;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;
    logic        m_rvalid;
    logic        m_rready;
    logic        busy;
    logic        grant_d;
    logic        prot_err;

    int n_asserts = 0;
    int n_fail    = 0;

    localparam logic [31:0] C_I_ADDR = 32'h1fc0_0020;
    localparam logic [31:0] C_D_ADDR = 32'h8000_1000;

    axi_rd_arbiter dut (
        .clk       (clk),       .resetn    (resetn),
        .i_araddr  (i_araddr),  .i_arlen   (i_arlen),   .i_arsize  (i_arsize),
        .i_arvalid (i_arvalid), .i_arready (i_arready),
        .i_rdata   (i_rdata),   .i_rresp   (i_rresp),   .i_rlast   (i_rlast),
        .i_rvalid  (i_rvalid),  .i_rready  (i_rready),
        .d_araddr  (d_araddr),  .d_arlen   (d_arlen),   .d_arsize  (d_arsize),
        .d_arvalid (d_arvalid), .d_arready (d_arready),
        .d_rdata   (d_rdata),   .d_rresp   (d_rresp),   .d_rlast   (d_rlast),
        .d_rvalid  (d_rvalid),  .d_rready  (d_rready),
        .m_arid    (m_arid),    .m_araddr  (m_araddr),  .m_arlen   (m_arlen),
        .m_arsize  (m_arsize),  .m_arburst (m_arburst), .m_arvalid (m_arvalid),
        .m_arready (m_arready), .m_rid     (m_rid),     .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),   .m_rlast   (m_rlast),   .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),  .busy      (busy),      .grant_d   (grant_d),
        .prot_err  (prot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        resetn    = 1'b0;
        i_arvalid = 1'b0; d_arvalid = 1'b0;
        i_rready  = 1'b0; d_rready  = 1'b0;
        m_arready = 1'b0; m_rvalid  = 1'b0; m_rlast = 1'b0;
        #1;
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_prot_err",  {31'd0, prot_err},  32'd0);
        chk("rst_grant_d",   {31'd0, grant_d},   32'd0);
        chk("rst_m_arvalid", {31'd0, m_arvalid}, 32'd0);
        chk("rst_m_rready",  {31'd0, m_rready},  32'd0);
        chk("rst_m_araddr",  m_araddr,           32'd0);
        chk("rst_m_arburst", {30'd0, m_arburst}, 32'd1);
        next_cyc();
        resetn = 1'b1;
    endtask

    // Present requests in an idle cycle and check the resulting AR issue.
    // The loser keeps its arvalid asserted; the winner drops it after AR.
    task automatic grant_round(input bit want_i, input bit want_d, input bit exp_d);
        logic [7:0] exp_len;
        i_arvalid = want_i;
        d_arvalid = want_d;
        m_arready = 1'b1;
        #1;
        chk("arb_latency_arvalid", {31'd0, m_arvalid}, 32'd0);
        next_cyc();
        exp_len = exp_d ? d_arlen : i_arlen;
        chk("ar_grant_d",  {31'd0, grant_d},   {31'd0, exp_d});
        chk("ar_m_arvalid",{31'd0, m_arvalid}, 32'd1);
        chk("ar_m_arid",   {28'd0, m_arid},    exp_d ? 32'd1 : 32'd3);
        chk("ar_m_araddr", m_araddr,           exp_d ? C_D_ADDR : C_I_ADDR);
        chk("ar_m_arlen",  {24'd0, m_arlen},   {24'd0, exp_len});
        chk("ar_win_ready",{31'd0, (exp_d ? d_arready : i_arready)}, 32'd1);
        chk("ar_lose_ready",{31'd0, (exp_d ? i_arready : d_arready)}, 32'd0);
        next_cyc();
        if (exp_d) d_arvalid = 1'b0; else i_arvalid = 1'b0;
        m_arready = 1'b0;
        chk("r_busy", {31'd0, busy}, 32'd1);
    endtask

    // Master streams nbeats with rlast on the final one; optional requester stall.
    task automatic r_phase(input bit to_d, input int nbeats, input logic [3:0] rid,
                           input int stall_beat, input int stall_cycles);
        int beat   = 0;
        int got    = 0;
        int stalls = 0;
        int cyc    = 0;
        logic stalled;
        while (beat < nbeats && cyc < 200) begin
            m_rvalid = 1'b1;
            m_rid    = rid;
            m_rresp  = 2'b00;
            m_rdata  = 32'hA5A5_0000 + beat;
            m_rlast  = (beat == nbeats - 1);
            stalled  = (beat == stall_beat) && (stalls < stall_cycles);
            if (to_d) d_rready = ~stalled; else i_rready = ~stalled;
            #1;
            if (stalled) begin
                chk("stall_m_rready", {31'd0, m_rready}, 32'd0);
                stalls++;
            end else begin
                chk("r_m_rready", {31'd0, m_rready}, 32'd1);
                chk("r_data", to_d ? d_rdata : i_rdata, 32'hA5A5_0000 + beat);
                chk("r_other_rvalid", {31'd0, (to_d ? i_rvalid : d_rvalid)}, 32'd0);
                if ((to_d ? d_rvalid : i_rvalid) === 1'b1) got++;
                beat++;
            end
            next_cyc();
            cyc++;
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        i_rready = 1'b0;
        d_rready = 1'b0;
        chk("beat_count", got, nbeats);
        chk("stall_cycles", stalls, stall_cycles);
        chk("end_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        resetn    = 1'b0;
        i_araddr  = C_I_ADDR; i_arlen = 8'd7; i_arsize = 3'd2; i_arvalid = 1'b0;
        d_araddr  = C_D_ADDR; d_arlen = 8'd0; d_arsize = 3'd2; d_arvalid = 1'b0;
        i_rready  = 1'b0; d_rready = 1'b0;
        m_arready = 1'b0; m_rid = 4'd0; m_rdata = '0; m_rresp = '0;
        m_rlast   = 1'b0; m_rvalid = 1'b0;
        next_cyc();
        apply_reset();

        // lone icache burst, 8 beats
        grant_round(1'b1, 1'b0, 1'b0);
        r_phase(1'b0, 8, 4'd3, -1, 0);
        chk("lone_prot_err", {31'd0, prot_err}, 32'd0);

        // contested: icache always requesting, short dcache bursts
        i_arlen = 8'd0;
        for (int r = 0; r < 4; r++) begin
            grant_round(1'b1, 1'b1, 1'b1);
            r_phase(1'b1, 1, 4'd1, -1, 0);
        end
        grant_round(1'b1, 1'b1, 1'b0);      // starved icache wins the 5th
        r_phase(1'b0, 1, 4'd3, -1, 0);
        grant_round(1'b1, 1'b1, 1'b1);      // counter was cleared: dcache again
        i_arvalid = 1'b0;
        r_phase(1'b1, 1, 4'd1, -1, 0);
        chk("contest_prot_err", {31'd0, prot_err}, 32'd0);

        // icache rready stall for 3 cycles at beat 3
        i_arlen = 8'd7;
        grant_round(1'b1, 1'b0, 1'b0);
        r_phase(1'b0, 8, 4'd3, 3, 3);
        chk("stall_prot_err", {31'd0, prot_err}, 32'd0);

        // wrong rid: data still delivered, error sticky
        grant_round(1'b1, 1'b0, 1'b0);
        r_phase(1'b0, 8, 4'd2, -1, 0);
        chk("rid_prot_err", {31'd0, prot_err}, 32'd1);
        next_cyc();
        next_cyc();
        chk("rid_prot_err_sticky", {31'd0, prot_err}, 32'd1);

        // early rlast on beat 5 of an 8-beat burst
        apply_reset();
        grant_round(1'b1, 1'b0, 1'b0);
        r_phase(1'b0, 5, 4'd3, -1, 0);
        chk("early_last_prot_err", {31'd0, prot_err}, 32'd1);

        // reset in the middle of a burst
        apply_reset();
        grant_round(1'b1, 1'b0, 1'b0);
        i_rready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            m_rvalid = 1'b1; m_rid = 4'd3; m_rlast = 1'b0;
            m_rdata  = 32'hC0DE_0000 + b;
            next_cyc();
        end
        m_rvalid = 1'b1;
        #1;
        chk("pre_rst_i_rvalid", {31'd0, i_rvalid}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("midrst_m_rready", {31'd0, m_rready}, 32'd0);
        chk("midrst_i_rvalid", {31'd0, i_rvalid}, 32'd0);
        chk("midrst_busy",     {31'd0, busy},     32'd0);
        next_cyc();
        m_rvalid = 1'b0;
        i_rready = 1'b0;
        resetn   = 1'b1;
        next_cyc();
        chk("post_rst_i_rvalid", {31'd0, i_rvalid}, 32'd0);
        d_arlen = 8'd3;
        grant_round(1'b0, 1'b1, 1'b1);
        r_phase(1'b1, 4, 4'd1, -1, 0);
        chk("post_rst_prot_err", {31'd0, prot_err}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule : tb_axi_rd_arbiter
`default_nettype wire
